// File: rtl/cvxif_issue_initiator_pkg.sv
// Shared CV-X-IF types for the issue initiator: interface structs, ID/hart types, FSM states.
package cvxif_issue_initiator_pkg;

  localparam int unsigned XLen         = 32;
  localparam int unsigned XNumRs       = 3;
  localparam int unsigned XIdWidth     = 4;
  localparam int unsigned XHartidWidth = 2;

  typedef logic [XIdWidth-1:0]     id_t;
  typedef logic [XHartidWidth-1:0] hartid_t;

  typedef struct packed {
    logic [31:0] instr;
    hartid_t     hartid;
    id_t         id;
  } x_issue_req_t;

  typedef struct packed {
    logic              accept;
    logic              writeback;
    logic [XNumRs-1:0] register_read;
  } x_issue_resp_t;

  typedef struct packed {
    hartid_t                      hartid;
    id_t                          id;
    logic [XNumRs-1:0][XLen-1:0] rs;
    logic [XNumRs-1:0]            rs_valid;
  } x_register_t;

  typedef struct packed {
    hartid_t         hartid;
    id_t             id;
    logic [XLen-1:0] data;
    logic [4:0]      rd;
    logic            we;
  } x_result_t;

  typedef enum logic [0:0] {StIdle, StIssue} issue_state_e;

endpackage

// File: rtl/cvxif_issue_initiator_if.sv
// Core-side and coprocessor-side signal bundle of the issue initiator.
interface cvxif_issue_initiator_if #(
  parameter int unsigned NrRgprPorts = 2
);
  import cvxif_issue_initiator_pkg::*;

  logic                              instr_valid_i;
  logic [31:0]                       instr_i;
  hartid_t                           hartid_i;
  logic [NrRgprPorts-1:0][XLen-1:0]  rs_i;
  logic [NrRgprPorts-1:0]            rs_valid_i;
  logic                              instr_ready_o;

  logic                              issue_valid_o;
  x_issue_req_t                      issue_req_o;
  logic                              issue_ready_i;
  x_issue_resp_t                     issue_resp_i;

  logic                              register_valid_o;
  x_register_t                       register_o;

  logic                              done_valid_o;
  id_t                               done_id_o;
  logic                              done_accept_o;
  logic                              done_illegal_o;

  logic                              result_valid_i;
  x_result_t                         result_i;
  logic                              result_ready_o;

  logic                              wb_valid_o;
  id_t                               wb_id_o;
  logic [4:0]                        wb_rd_o;
  logic [XLen-1:0]                   wb_data_o;
  logic                              wb_we_o;
  logic                              wb_ready_i;
  logic                              spurious_o;

  modport master (
    input  instr_valid_i, instr_i, hartid_i, rs_i, rs_valid_i,
    input  issue_ready_i, issue_resp_i, result_valid_i, result_i, wb_ready_i,
    output instr_ready_o, issue_valid_o, issue_req_o, register_valid_o, register_o,
    output done_valid_o, done_id_o, done_accept_o, done_illegal_o, result_ready_o,
    output wb_valid_o, wb_id_o, wb_rd_o, wb_data_o, wb_we_o, spurious_o
  );

  modport slave (
    output instr_valid_i, instr_i, hartid_i, rs_i, rs_valid_i,
    output issue_ready_i, issue_resp_i, result_valid_i, result_i, wb_ready_i,
    input  instr_ready_o, issue_valid_o, issue_req_o, register_valid_o, register_o,
    input  done_valid_o, done_id_o, done_accept_o, done_illegal_o, result_ready_o,
    input  wb_valid_o, wb_id_o, wb_rd_o, wb_data_o, wb_we_o, spurious_o
  );

endinterface

// File: rtl/cvxif_id_allocator.sv
// Busy bitmap of in-flight offload IDs with lowest-free-index allocation and a full flag.
module cvxif_id_allocator #(
  parameter int unsigned NrIds = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     alloc_i,
  input  logic [NrIds-1:0]         free_i,
  output logic [NrIds-1:0]         busy_o,
  output logic [$clog2(NrIds)-1:0] free_id_o,
  output logic                     full_o
);

  localparam int unsigned IdW = $clog2(NrIds);

  logic [NrIds-1:0] busy_q, busy_d;

  // Scan downwards so the lowest free index is the one left standing.
  always_comb begin
    free_id_o = '0;
    for (int i = int'(NrIds) - 1; i >= 0; i--) begin
      if (!busy_q[i]) free_id_o = IdW'(i);
    end
  end

  assign full_o = &busy_q;
  assign busy_o = busy_q;

  // Allocation only ever sees the registered bitmap, so a bit freed this cycle is not reused yet.
  always_comb begin
    busy_d = busy_q & ~free_i;
    if (alloc_i && !full_o) busy_d = busy_d | (NrIds'(1) << free_id_o);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) busy_q <= '0;
    else         busy_q <= busy_d;
  end

endmodule

// File: rtl/cvxif_issue_initiator.sv
// CV-X-IF issue initiator: offload issue FSM, ID free-list and result writeback routing.
// Optional issue-handshake watchdog enabled by defining CVXIF_ISSUE_TIMEOUT_EN.
module cvxif_issue_initiator
  import cvxif_issue_initiator_pkg::*;
#(
  parameter int unsigned NrRgprPorts   = 2,
  parameter int unsigned NrIds         = 4,
  parameter int unsigned TimeoutCycles = 64
) (
  input logic                     clk_i,
  input logic                     rst_ni,
  cvxif_issue_initiator_if.master cvxif_io
);

  localparam int unsigned IdW = $clog2(NrIds);

  issue_state_e                 state_q, state_d;
  logic [31:0]                  instr_q;
  hartid_t                      hartid_q;
  logic [XNumRs-1:0][XLen-1:0]  rs_q, rs_in;
  logic [XNumRs-1:0]            rs_valid_q, rs_valid_in;
  logic [IdW-1:0]               id_q;

  logic [NrIds-1:0] busy, free_mask;
  logic [IdW-1:0]   free_id, res_id;
  logic             full, alloc, issue_fire, timeout, done, done_acc;
  logic             res_ready, res_fire, res_known, wb_fire;

  cvxif_id_allocator #(
    .NrIds(NrIds)
  ) u_id_allocator (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .alloc_i  (alloc),
    .free_i   (free_mask),
    .busy_o   (busy),
    .free_id_o(free_id),
    .full_o   (full)
  );

  // Ready outputs are gated by reset so nothing handshakes while the block is held in reset.
  assign alloc      = (state_q == StIdle) && cvxif_io.instr_valid_i && !full && rst_ni;
  assign issue_fire = (state_q == StIssue) && cvxif_io.issue_ready_i;
  assign done       = issue_fire || timeout;
  assign done_acc   = issue_fire && cvxif_io.issue_resp_i.accept;

  assign res_ready = cvxif_io.wb_ready_i && rst_ni;
  assign res_fire  = cvxif_io.result_valid_i && res_ready;
  assign res_id    = cvxif_io.result_i.id[IdW-1:0];
  assign res_known = ((cvxif_io.result_i.id >> IdW) == '0) && busy[res_id];
  assign wb_fire   = res_fire && res_known;

`ifdef CVXIF_ISSUE_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
  logic [CntW-1:0] cnt_q, cnt_d;

  assign timeout = (state_q == StIssue) && !cvxif_io.issue_ready_i &&
                   (cnt_q == CntW'(TimeoutCycles - 1));
  assign cnt_d   = ((state_q == StIssue) && !done) ? cnt_q + CntW'(1) : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
`else
  logic unused_timeout;
  assign timeout        = 1'b0;
  assign unused_timeout = ^TimeoutCycles;
`endif

  always_comb begin
    free_mask = '0;
    if ((issue_fire && !done_acc) || timeout) free_mask[id_q] = 1'b1;
    if (wb_fire) free_mask[res_id] = 1'b1;
  end

  always_comb begin
    rs_in       = '0;
    rs_valid_in = '0;
    for (int unsigned i = 0; i < NrRgprPorts; i++) begin
      rs_in[i]       = cvxif_io.rs_i[i];
      rs_valid_in[i] = cvxif_io.rs_valid_i[i];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (alloc) state_d = StIssue;
      StIssue: if (done) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      instr_q    <= '0;
      hartid_q   <= '0;
      rs_q       <= '0;
      rs_valid_q <= '0;
      id_q       <= '0;
    end else begin
      state_q <= state_d;
      if (alloc) begin
        instr_q    <= cvxif_io.instr_i;
        hartid_q   <= cvxif_io.hartid_i;
        rs_q       <= rs_in;
        rs_valid_q <= rs_valid_in;
        id_q       <= free_id;
      end
    end
  end

  assign cvxif_io.instr_ready_o    = alloc;
  assign cvxif_io.issue_valid_o    = (state_q == StIssue);
  assign cvxif_io.issue_req_o      = '{instr: instr_q, hartid: hartid_q, id: id_t'(id_q)};
  assign cvxif_io.register_valid_o = (state_q == StIssue);
  assign cvxif_io.register_o       = '{hartid: hartid_q, id: id_t'(id_q), rs: rs_q,
                                       rs_valid: rs_valid_q};

  assign cvxif_io.done_valid_o   = done;
  assign cvxif_io.done_id_o      = done ? id_t'(id_q) : '0;
  assign cvxif_io.done_accept_o  = done_acc;
  assign cvxif_io.done_illegal_o = done && !done_acc;

  assign cvxif_io.result_ready_o = res_ready;
  assign cvxif_io.wb_valid_o     = wb_fire;
  assign cvxif_io.wb_id_o        = wb_fire ? cvxif_io.result_i.id : '0;
  assign cvxif_io.wb_rd_o        = wb_fire ? cvxif_io.result_i.rd : '0;
  assign cvxif_io.wb_data_o      = wb_fire ? cvxif_io.result_i.data : '0;
  assign cvxif_io.wb_we_o        = wb_fire && cvxif_io.result_i.we;
  assign cvxif_io.spurious_o     = res_fire && !res_known;

  logic unused_fields;
  assign unused_fields = ^{cvxif_io.issue_resp_i.writeback, cvxif_io.issue_resp_i.register_read,
                           cvxif_io.result_i.hartid};

endmodule
